// File: rtl/urng_pair_src_pkg.sv
// Shared definitions for the uniform-pair source.
//   - default generator seeds
//   - double-precision exponent bias and the bias used for 53-bit fixed point
//   - burst controller state encoding
//   - one step of the 64-bit xorshift generator
package urng_pair_src_pkg;

  localparam logic [63:0] SEED1_DFLT = 64'h9E3779B97F4A7C15;
  localparam logic [63:0] SEED2_DFLT = 64'hD1B54A32D192ED03;

  localparam int unsigned EXP_BIAS   = 1023;
  // A 53-bit integer r scaled by 2^-53 with MSB at bit p has exponent p-53.
  localparam int unsigned EXP_BIAS_U = EXP_BIAS - 53;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_FLUSH
  } state_t;

  function automatic logic [63:0] xs64_next(input logic [63:0] x);
    logic [63:0] y;
    y = x;
    y = y ^ (y << 13);
    y = y ^ (y >> 7);
    y = y ^ (y << 17);
    return y;
  endfunction

endpackage

// File: rtl/urng_pair_src_if.sv
// Push bus from the uniform-pair source to the Gaussian transform.
//   pushout : pair valid this cycle (no backpressure)
//   U1, U2  : uniform doubles in (0,1)
// master drives the bus, slave consumes it.
interface urng_pair_src_if;
  logic        pushout;
  logic [63:0] U1;
  logic [63:0] U2;

  modport master (output pushout, output U1, output U2);
  modport slave  (input  pushout, input  U1, input  U2);
endinterface

// File: rtl/urng_pair_src_u53_to_fp64.sv
// Exact conversion of a 53-bit integer r to the double r*2^-53.
// Zero is treated as 1 so the result always lies in the open interval (0,1).
//   i_raw : 53-bit unsigned input
//   o_fp  : IEEE-754 double, sign always 0
module u53_to_fp64
  import urng_pair_src_pkg::*;
(
  input  logic [52:0] i_raw,
  output logic [63:0] o_fp
);

  logic [52:0] w_r;
  logic [5:0]  w_p;
  logic [51:0] w_frac;
  logic [10:0] w_exp;

  always_comb begin
    w_r = (i_raw == '0) ? 53'd1 : i_raw;

    w_p = '0;
    for (int unsigned i = 0; i < 53; i++) begin
      if (w_r[i]) w_p = 6'(i);
    end

    // Shifting the low 52 bits pushes the leading one out of the top,
    // leaving the fraction left-justified and zero-filled.
    w_frac = w_r[51:0] << (6'd52 - w_p);
    w_exp  = 11'(EXP_BIAS_U) + 11'(w_p);
    o_fp   = {1'b0, w_exp, w_frac};
  end

endmodule

// File: rtl/urng_pair_src.sv
// Uniform-pair source for the Box-Muller transform.
// Two xorshift64 generators feed a two-stage pipeline (issue, convert) that
// emits one (U1,U2) pair per clock for a go/count burst.
//   clk, rst          : clock, asynchronous active-low reset
//   seed_ld/seed1/2   : reload generators (IDLE only, zero -> default seed)
//   go/count          : start a burst of count pairs (IDLE only)
//   abort             : stop issuing; pairs already issued still emerge
//   busy, done        : burst in progress / one-cycle end-of-burst pulse
//   push              : pushout/U1/U2 bus towards the transform
module urng_pair_src
  import urng_pair_src_pkg::*;
#(
  parameter logic [63:0] SEED1 = SEED1_DFLT,
  parameter logic [63:0] SEED2 = SEED2_DFLT,
  parameter int unsigned CW    = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          seed_ld,
  input  logic [63:0]   seed1,
  input  logic [63:0]   seed2,
  input  logic          go,
  input  logic [CW-1:0] count,
  input  logic          abort,
  output logic          busy,
  output logic          done,
  urng_pair_src_if.master push
);

  state_t        r_state;
  logic [63:0]   r_x1;
  logic [63:0]   r_x2;
  logic [CW-1:0] r_rem;
  logic          r_flush_arm;
  logic [52:0]   r_raw1;
  logic [52:0]   r_raw2;
  logic          r_v1;
  logic          r_done;
  logic          r_busy;
  logic          r_pushout;
  logic [63:0]   r_u1;
  logic [63:0]   r_u2;

  logic          w_issue;
  logic [63:0]   w_nx1;
  logic [63:0]   w_nx2;
  logic [63:0]   w_fp1;
  logic [63:0]   w_fp2;

  assign w_issue = (r_state == ST_RUN) && !abort;
  assign w_nx1   = xs64_next(r_x1);
  assign w_nx2   = xs64_next(r_x2);

  // Burst controller and issue stage.
  // FLUSH ends once the issue stage is empty; r_flush_arm is pre-set when
  // coming from RUN so done lands the cycle after the final pushout, and
  // left clear for a zero-length burst so it still takes the nominal
  // two-cycle pipeline latency.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= ST_IDLE;
      r_x1        <= SEED1;
      r_x2        <= SEED2;
      r_rem       <= '0;
      r_flush_arm <= 1'b0;
      r_raw1      <= '0;
      r_raw2      <= '0;
      r_v1        <= 1'b0;
      r_done      <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_v1   <= w_issue;
      if (w_issue) begin
        r_x1   <= w_nx1;
        r_x2   <= w_nx2;
        r_raw1 <= w_nx1[63:11];
        r_raw2 <= w_nx2[63:11];
      end

      case (r_state)
        ST_IDLE: begin
          if (seed_ld) begin
            r_x1 <= (seed1 == '0) ? SEED1 : seed1;
            r_x2 <= (seed2 == '0) ? SEED2 : seed2;
          end
          if (go) begin
            r_busy <= 1'b1;
            if (count != '0) begin
              r_state <= ST_RUN;
              r_rem   <= count;
            end else begin
              r_state     <= ST_FLUSH;
              r_flush_arm <= 1'b0;
            end
          end
        end

        ST_RUN: begin
          if (!abort) r_rem <= r_rem - CW'(1);
          if (abort || (r_rem == CW'(1))) begin
            r_state     <= ST_FLUSH;
            r_flush_arm <= 1'b1;
          end
        end

        ST_FLUSH: begin
          if (r_flush_arm && !r_v1) begin
            r_state     <= ST_IDLE;
            r_flush_arm <= 1'b0;
            r_done      <= 1'b1;
            r_busy      <= 1'b0;
          end else begin
            r_flush_arm <= 1'b1;
          end
        end

        default: r_state <= ST_IDLE;
      endcase
    end
  end

  u53_to_fp64 u_cvt1 (.i_raw(r_raw1), .o_fp(w_fp1));
  u53_to_fp64 u_cvt2 (.i_raw(r_raw2), .o_fp(w_fp2));

  // Convert stage: registered doubles and strobe.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pushout <= 1'b0;
      r_u1      <= '0;
      r_u2      <= '0;
    end else begin
      r_pushout <= r_v1;
      if (r_v1) begin
        r_u1 <= w_fp1;
        r_u2 <= w_fp2;
      end
    end
  end

  assign busy         = r_busy;
  assign done         = r_done;
  assign push.pushout = r_pushout;
  assign push.U1      = r_u1;
  assign push.U2      = r_u2;

endmodule

// File: tb/tb_urng_pair_src.sv
module tb_urng_pair_src;

  localparam int unsigned CW = 16;
  localparam logic [63:0] S1 = 64'h9E3779B97F4A7C15;
  localparam logic [63:0] S2 = 64'hD1B54A32D192ED03;

  logic          clk;
  logic          rst;
  logic          seed_ld;
  logic [63:0]   seed1;
  logic [63:0]   seed2;
  logic          go;
  logic [CW-1:0] count;
  logic          abort;
  logic          busy;
  logic          done;

  logic [52:0]   t_raw;
  logic [63:0]   t_fp;

  int unsigned   n_tests;
  int unsigned   n_fail;
  logic [63:0]   m1;
  logic [63:0]   m2;
  logic [63:0]   last_u2;

  urng_pair_src_if push_if ();

  urng_pair_src #(.SEED1(S1), .SEED2(S2), .CW(CW)) dut (
    .clk    (clk),
    .rst    (rst),
    .seed_ld(seed_ld),
    .seed1  (seed1),
    .seed2  (seed2),
    .go     (go),
    .count  (count),
    .abort  (abort),
    .busy   (busy),
    .done   (done),
    .push   (push_if)
  );

  u53_to_fp64 u_cvt (.i_raw(t_raw), .o_fp(t_fp));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] xs(input logic [63:0] x);
    logic [63:0] y;
    y = x ^ (x << 13);
    y = y ^ (y >> 7);
    y = y ^ (y << 17);
    return y;
  endfunction

  // Reference conversion through real arithmetic: r*2^-53 is exact in a double.
  function automatic logic [63:0] conv_ref(input logic [52:0] r);
    logic [52:0] rr;
    real v;
    rr = (r == '0) ? 53'd1 : r;
    v  = real'(rr) / 9007199254740992.0;
    return $realtobits(v);
  endfunction

  task automatic check_idle_outputs(input string tag);
    check_eq({tag, " pushout"}, {63'b0, push_if.pushout}, 64'd0);
    check_eq({tag, " U1"},      push_if.U1, 64'd0);
    check_eq({tag, " U2"},      push_if.U2, 64'd0);
    check_eq({tag, " done"},    {63'b0, done}, 64'd0);
    check_eq({tag, " busy"},    {63'b0, busy}, 64'd0);
  endtask

  // go sampled at edge E0; k counts edges after E0. abort_k is the edge at
  // which abort is sampled (0 = no abort). With m pairs issued, pushout is
  // high for k=2..m+1, done at k=m+2, busy for k=0..m+1.
  task automatic burst(input int n, input int abort_k, input bit go_again, input bit do_seed);
    int m;
    logic exp_po;
    m = (abort_k > 0 && abort_k <= n) ? abort_k - 1 : n;
    if (do_seed) begin
      seed_ld = 1'b1;
      seed1   = 64'd0;
      seed2   = 64'd1;
      m1      = S1;
      m2      = 64'd1;
    end
    go    = 1'b1;
    count = CW'(n);
    tick();
    go      = 1'b0;
    seed_ld = 1'b0;
    for (int k = 0; k <= m + 4; k++) begin
      if (k > 0) tick();
      abort = (abort_k > 0) && (k + 1 == abort_k);
      go    = go_again && (k == 4);
      exp_po = (k >= 2) && (k <= m + 1);
      check_eq($sformatf("pushout n=%0d k=%0d", n, k), {63'b0, push_if.pushout}, {63'b0, exp_po});
      check_eq($sformatf("done n=%0d k=%0d", n, k), {63'b0, done}, {63'b0, (k == m + 2)});
      check_eq($sformatf("busy n=%0d k=%0d", n, k), {63'b0, busy}, {63'b0, (k <= m + 1)});
      if (exp_po) begin
        m1 = xs(m1);
        m2 = xs(m2);
        check_eq($sformatf("U1 n=%0d k=%0d", n, k), push_if.U1, conv_ref(m1[63:11]));
        check_eq($sformatf("U2 n=%0d k=%0d", n, k), push_if.U2, conv_ref(m2[63:11]));
        last_u2 = push_if.U2;
      end
    end
    abort = 1'b0;
    go    = 1'b0;
  endtask

  initial begin
    logic [52:0] raw_tab [5];
    logic [63:0] fp_tab  [5];

    n_tests = 0;
    n_fail  = 0;
    rst     = 1'b0;
    seed_ld = 1'b0;
    seed1   = '0;
    seed2   = '0;
    go      = 1'b0;
    count   = '0;
    abort   = 1'b0;
    t_raw   = '0;
    last_u2 = '0;

    #3;
    check_idle_outputs("reset");

    raw_tab[0] = 53'h10000000000000; fp_tab[0] = 64'h3FE0000000000000;
    raw_tab[1] = 53'd1;              fp_tab[1] = 64'h3CA0000000000000;
    raw_tab[2] = 53'd0;              fp_tab[2] = 64'h3CA0000000000000;
    raw_tab[3] = 53'h1FFFFFFFFFFFFF; fp_tab[3] = 64'h3FEFFFFFFFFFFFFF;
    raw_tab[4] = 53'd3;              fp_tab[4] = 64'h3CB8000000000000;
    for (int i = 0; i < 5; i++) begin
      t_raw = raw_tab[i];
      #1;
      check_eq($sformatf("cvt r=%h", raw_tab[i]), t_fp, fp_tab[i]);
    end

    tick();
    tick();
    rst = 1'b1;
    tick();

    m1 = S1;
    m2 = S2;
    burst(4, 0, 1'b0, 1'b0);
    burst(0, 0, 1'b0, 1'b0);
    burst(1, 0, 1'b0, 1'b0);
    burst(100, 12, 1'b1, 1'b0);
    tick();
    check_eq("idle after abort busy", {63'b0, busy}, 64'd0);
    check_eq("idle after abort pushout", {63'b0, push_if.pushout}, 64'd0);

    burst(1, 0, 1'b0, 1'b1);
    check_eq("seed2=1 U2 hand value", last_u2, 64'h3DD0208800000000);

    go    = 1'b1;
    count = CW'(20);
    tick();
    go = 1'b0;
    repeat (5) tick();
    #2;
    rst = 1'b0;
    #1;
    check_idle_outputs("async reset mid-burst");
    tick();
    check_eq("in reset pushout", {63'b0, push_if.pushout}, 64'd0);
    #2;
    rst = 1'b1;
    tick();
    check_idle_outputs("after release");

    m1 = S1;
    m2 = S2;
    burst(4, 0, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
